// File: rtl/lpc_sched_pkg.sv
// lpc_sched_pkg: shared state encoding, error codes and defaults for the LPC frame scheduler.
package lpc_sched_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        ISSUE_WR,
        ISSUE_RD,
        RUN,
        CHECK,
        FINISH,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CAL   = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_BEATS = 2'd3;

    localparam int DEF_BYTES_PER_SAMPLE = 2;
endpackage

// File: rtl/lpc_addr_gen.sv
// lpc_addr_gen: read/write address accumulators, loaded with the bases and stepped once per frame.
module lpc_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [ADDR_W-1:0] hop_bytes_i,
    input  logic [ADDR_W-1:0] len_bytes_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o
);
    logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d;

    always_comb begin
        rd_d = load_i ? src_base_i : step_i ? rd_q + hop_bytes_i : rd_q;
        wr_d = load_i ? dst_base_i : step_i ? wr_q + len_bytes_i : wr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    assign rd_addr_o = rd_q;
    assign wr_addr_o = wr_q;
endmodule

// File: rtl/lpc_frame_scheduler.sv
// lpc_frame_scheduler: sequences per-frame write/read master commands through the DDR3 loopback,
// checks the stream beat count of each frame and reports status.
module lpc_frame_scheduler
    import lpc_sched_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter int LEN_W            = 16,
    parameter int NFR_W            = 16,
    parameter int BYTES_PER_SAMPLE = DEF_BYTES_PER_SAMPLE
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              local_init_done,
    input  logic              local_cal_success,
    input  logic              local_cal_fail,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [LEN_W-1:0]  cfg_hop,
    input  logic [NFR_W-1:0]  cfg_num_frames,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [NFR_W-1:0]  frame_idx,
    output logic              rd_go,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_len,
    input  logic              rd_done,
    output logic              wr_go,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wr_len,
    input  logic              wr_done,
    input  logic              stream_v
);
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [NFR_W-1:0]  nfr_q, nfr_d, idx_q, idx_d;
    logic [ADDR_W-1:0] len_bytes_q, len_bytes_d, hop_bytes_q, hop_bytes_d;
    logic [LEN_W:0]    beat_q, beat_d;
    logic              rd_f_q, rd_f_d, wr_f_q, wr_f_d, err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              rest, load, step;

    assign rest = state_q inside {IDLE, FINISH, ERROR};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nfr_d       = nfr_q;
        idx_d       = idx_q;
        len_bytes_d = len_bytes_q;
        hop_bytes_d = hop_bytes_q;
        beat_d      = beat_q;
        rd_f_d      = rd_f_q;
        wr_f_d      = wr_f_q;
        err_d       = err_q;
        code_d      = code_q;
        load        = 1'b0;
        step        = 1'b0;
        if (start && rest) begin
            state_d     = WAIT_CAL;
            len_d       = cfg_frame_len;
            nfr_d       = cfg_num_frames;
            idx_d       = '0;
            len_bytes_d = ADDR_W'(cfg_frame_len) * ADDR_W'(BYTES_PER_SAMPLE);
            hop_bytes_d = ADDR_W'(cfg_hop) * ADDR_W'(BYTES_PER_SAMPLE);
            err_d       = 1'b0;
            code_d      = ERR_NONE;
            load        = 1'b1;
        end else begin
            case (state_q)
                WAIT_CAL: begin
                    if (local_cal_fail) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_CAL;
                    end else if (len_q == '0) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else if (nfr_q == '0) begin
                        state_d = FINISH;
                    end else if (local_init_done && local_cal_success) begin
                        state_d = ISSUE_WR;
                    end
                end
                ISSUE_WR: begin
                    state_d = ISSUE_RD;
                    rd_f_d  = 1'b0;
                    wr_f_d  = 1'b0;
                    beat_d  = '0;
                end
                ISSUE_RD: state_d = RUN;
                RUN: begin
                    rd_f_d = rd_f_q | rd_done;
                    wr_f_d = wr_f_q | wr_done;
                    // saturate so a runaway stream can never wrap back into a match
                    if (stream_v && beat_q != '1) beat_d = beat_q + (LEN_W+1)'(1);
                    if (rd_f_d && wr_f_d) state_d = CHECK;
                end
                CHECK: begin
                    if (beat_q != {1'b0, len_q}) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_BEATS;
                    end else if (idx_q == nfr_q - NFR_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE_WR;
                        idx_d   = idx_q + NFR_W'(1);
                        step    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            nfr_q       <= '0;
            idx_q       <= '0;
            len_bytes_q <= '0;
            hop_bytes_q <= '0;
            beat_q      <= '0;
            rd_f_q      <= 1'b0;
            wr_f_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nfr_q       <= nfr_d;
            idx_q       <= idx_d;
            len_bytes_q <= len_bytes_d;
            hop_bytes_q <= hop_bytes_d;
            beat_q      <= beat_d;
            rd_f_q      <= rd_f_d;
            wr_f_q      <= wr_f_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    lpc_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .load_i     (load),
        .step_i     (step),
        .src_base_i (cfg_src_base),
        .dst_base_i (cfg_dst_base),
        .hop_bytes_i(hop_bytes_q),
        .len_bytes_i(len_bytes_q),
        .rd_addr_o  (rd_addr),
        .wr_addr_o  (wr_addr)
    );

    // strobes are masked by reset so a reset landing in an issue cycle never commands a master
    assign wr_go     = reset_reset_n && state_q == ISSUE_WR;
    assign rd_go     = reset_reset_n && state_q == ISSUE_RD;
    assign busy      = !rest;
    assign done      = state_q == FINISH;
    assign error     = err_q;
    assign err_code  = code_q;
    assign frame_idx = idx_q;
    assign rd_len    = len_bytes_q;
    assign wr_len    = len_bytes_q;
endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// tb_lpc_frame_scheduler: table-driven jobs with a go-command scoreboard and a master/stream responder.
module tb_lpc_frame_scheduler;
    logic        clk_clk = 1'b0, reset_reset_n = 1'b0;
    logic        local_init_done = 1'b0, local_cal_success = 1'b0, local_cal_fail = 1'b0;
    logic [31:0] cfg_src_base = '0, cfg_dst_base = '0;
    logic [15:0] cfg_frame_len = '0, cfg_hop = '0, cfg_num_frames = '0;
    logic        start = 1'b0, rd_done = 1'b0, wr_done = 1'b0, stream_v = 1'b0;
    logic        busy, done, error, rd_go, wr_go;
    logic [1:0]  err_code;
    logic [15:0] frame_idx;
    logic [31:0] rd_addr, rd_len, wr_addr, wr_len;

    int checks = 0, errors = 0;

    typedef struct { logic [31:0] addr; logic [31:0] len; } go_t;
    go_t wr_exp[$], rd_exp[$];

    typedef struct {
        logic [31:0] src, dst;
        int len, hop, nfr, shortf, wr_dly, rd_dly, cal_delay;
        bit cal_fail, exp_done;
        logic [1:0] exp_code;
        int exp_idx;
    } vec_t;
    vec_t tab[10];

    int cur_len, cur_short = -1, cur_wr_dly, cur_rd_dly;

    lpc_frame_scheduler dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .local_init_done(local_init_done), .local_cal_success(local_cal_success),
        .local_cal_fail(local_cal_fail),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .cfg_frame_len(cfg_frame_len), .cfg_hop(cfg_hop), .cfg_num_frames(cfg_num_frames),
        .start(start), .busy(busy), .done(done), .error(error), .err_code(err_code),
        .frame_idx(frame_idx),
        .rd_go(rd_go), .rd_addr(rd_addr), .rd_len(rd_len), .rd_done(rd_done),
        .wr_go(wr_go), .wr_addr(wr_addr), .wr_len(wr_len), .wr_done(wr_done),
        .stream_v(stream_v)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] src, dst, input int len, hop, nfr, shortf,
                                wr_dly, rd_dly, cal_delay, input bit cal_fail, exp_done,
                                input logic [1:0] exp_code, input int exp_idx);
        vec_t v;
        v.src = src; v.dst = dst; v.len = len; v.hop = hop; v.nfr = nfr; v.shortf = shortf;
        v.wr_dly = wr_dly; v.rd_dly = rd_dly; v.cal_delay = cal_delay; v.cal_fail = cal_fail;
        v.exp_done = exp_done; v.exp_code = exp_code; v.exp_idx = exp_idx;
        return v;
    endfunction

    // master model: after rd_go, streams the frame's beats, then pulses wr_done/rd_done at set delays
    initial begin : responder
        int cnt, left;
        bit act;
        cnt = 0; left = 0; act = 0;
        forever begin
            @(negedge clk_clk);
            stream_v = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
            if (!reset_reset_n) act = 0;
            if (act) begin
                cnt++;
                if (left > 0) begin stream_v = 1'b1; left--; end
                wr_done = (cnt == cur_wr_dly);
                rd_done = (cnt == cur_rd_dly);
                if (cnt >= cur_wr_dly && cnt >= cur_rd_dly) act = 0;
            end
            if (rd_go) begin
                act = 1; cnt = 0;
                left = (int'(frame_idx) == cur_short) ? cur_len - 1 : cur_len;
            end
        end
    end

    initial begin : monitor
        go_t e;
        logic wr_go_prev;
        wr_go_prev = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (wr_go) begin
                chk("wr_go_expected", 64'(wr_exp.size() > 0), 1);
                if (wr_exp.size() > 0) begin
                    e = wr_exp.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_len", wr_len, e.len);
                end
            end
            if (rd_go) begin
                chk("rd_go_expected", 64'(rd_exp.size() > 0), 1);
                chk("rd_go_follows_wr_go", wr_go_prev, 1);
                if (rd_exp.size() > 0) begin
                    e = rd_exp.pop_front();
                    chk("rd_addr", rd_addr, e.addr);
                    chk("rd_len", rd_len, e.len);
                end
            end
            wr_go_prev = wr_go;
        end
    end

    int done_cnt = 0;
    always @(posedge clk_clk) if (done) done_cnt <= done_cnt + 1;

    task automatic run_job(input vec_t v);
        int ngo, i, go_before;
        cur_len = v.len; cur_short = v.shortf; cur_wr_dly = v.wr_dly; cur_rd_dly = v.rd_dly;
        cfg_src_base = v.src; cfg_dst_base = v.dst;
        cfg_frame_len = 16'(v.len); cfg_hop = 16'(v.hop); cfg_num_frames = 16'(v.nfr);
        local_cal_fail = v.cal_fail;
        local_init_done = (v.cal_delay == 0);
        local_cal_success = (v.cal_delay == 0);
        ngo = (v.cal_fail || v.len == 0 || v.nfr == 0) ? 0 :
              (v.shortf >= 0 && v.shortf < v.nfr) ? v.shortf + 1 : v.nfr;
        for (int f = 0; f < ngo; f++) begin
            wr_exp.push_back(go_t'{v.dst + 32'(f * v.len * 2), 32'(v.len * 2)});
            rd_exp.push_back(go_t'{v.src + 32'(f * v.hop * 2), 32'(v.len * 2)});
        end
        @(negedge clk_clk);
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_cleared_by_start", error, 0);
        chk("err_code_cleared_by_start", err_code, 0);
        if (v.cal_delay > 0) begin
            go_before = 0;
            repeat (v.cal_delay) begin
                @(negedge clk_clk);
                if (wr_go || rd_go) go_before++;
            end
            chk("go_before_cal", go_before, 0);
            local_init_done = 1'b1; local_cal_success = 1'b1;
            @(negedge clk_clk);
            chk("wr_go_one_cycle_after_cal", wr_go, 1);
        end else begin
            @(negedge clk_clk);
            chk("wr_go_start_latency", wr_go, 64'(ngo > 0));
        end
        i = 0;
        while (!done && !error && i < 3000) begin
            @(negedge clk_clk);
            i++;
        end
        chk("job_timeout", 64'(i < 3000), 1);
        repeat (3) @(negedge clk_clk);
        chk("done_pulses", done_cnt, v.exp_done);
        chk("error", error, v.exp_code != 2'd0);
        chk("err_code", err_code, v.exp_code);
        chk("frame_idx", frame_idx, v.exp_idx);
        chk("busy_at_rest", busy, 0);
        chk("wr_go_outstanding", wr_exp.size(), 0);
        chk("rd_go_outstanding", rd_exp.size(), 0);
        wr_exp.delete(); rd_exp.delete();
        local_cal_fail = 1'b0; local_init_done = 1'b1; local_cal_success = 1'b1;
    endtask

    initial begin
        int i;
        //           src            dst            len  hop  nfr sh  wr   rd  cal f done code idx
        tab[0] = mk(32'h0000_1000, 32'h0000_8000, 256, 128, 3, -1, 300, 300,  0, 0, 1, 2'd0, 2);
        tab[1] = mk(32'h0000_2000, 32'h0000_3000,  16,  16, 2, -1,  20,  20, 50, 0, 1, 2'd0, 1);
        tab[2] = mk(32'h0000_2000, 32'h0000_3000,  16,  16, 2, -1,  20,  20,  0, 1, 0, 2'd1, 0);
        tab[3] = mk(32'h0000_2000, 32'h0000_3000,   0,  16, 3, -1,  20,  20,  0, 0, 0, 2'd2, 0);
        tab[4] = mk(32'h0000_2000, 32'h0000_3000,  16,  16, 0, -1,  20,  20,  0, 0, 1, 2'd0, 0);
        tab[5] = mk(32'h0001_0000, 32'h0002_0000,  16,   8, 4,  1,  20,  20,  0, 0, 0, 2'd3, 1);
        tab[6] = mk(32'h0000_0100, 32'h0000_0400,  16,   4, 2, -1,  17,  17,  0, 0, 1, 2'd0, 1);
        tab[7] = mk(32'h0000_0500, 32'h0000_0900,  16,  12, 2, -1,  20, 120,  0, 0, 1, 2'd0, 1);
        tab[8] = mk(32'hFFFF_FF80, 32'hFFFF_FFC0,  32,  64, 3, -1,  40,  40,  0, 0, 1, 2'd0, 2);
        tab[9] = mk(32'h0000_0000, 32'h0000_0000,  16,  16, 2,  0,  20,  20,  0, 0, 0, 2'd3, 0);
        repeat (3) @(negedge clk_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_go", {rd_go, wr_go}, 0);
        chk("rst_addrs", {rd_addr, wr_addr}, 0);
        chk("rst_lens", {rd_len, wr_len}, 0);
        reset_reset_n = 1'b1; local_init_done = 1'b1; local_cal_success = 1'b1;
        foreach (tab[k]) run_job(tab[k]);

        // reset landing in the wr_go cycle must suppress the strobe
        cfg_src_base = 32'h40; cfg_dst_base = 32'h80; cfg_frame_len = 16; cfg_hop = 16;
        cfg_num_frames = 2; cur_len = 16; cur_short = -1; cur_wr_dly = 200; cur_rd_dly = 200;
        wr_exp.push_back(go_t'{32'h80, 32'd32}); rd_exp.push_back(go_t'{32'h40, 32'd32});
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        #1;
        chk("reset_masks_wr_go", wr_go, 0);
        @(negedge clk_clk);
        chk("reset_in_issue_busy", busy, 0);
        reset_reset_n = 1'b1;
        wr_exp.delete(); rd_exp.delete();

        // reset in RUN clears every output on the next cycle
        wr_exp.push_back(go_t'{32'h80, 32'd32}); rd_exp.push_back(go_t'{32'h40, 32'd32});
        @(negedge clk_clk);
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        i = 0;
        while (!rd_go && i < 20) begin
            @(negedge clk_clk);
            i++;
        end
        chk("reached_run", rd_go, 1);
        repeat (10) @(negedge clk_clk);
        chk("in_run_busy", busy, 1);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("run_rst_busy_done_err", {busy, done, error, err_code}, 0);
        chk("run_rst_go", {rd_go, wr_go}, 0);
        chk("run_rst_frame_idx", frame_idx, 0);
        chk("run_rst_addrs", {rd_addr, wr_addr}, 0);
        chk("run_rst_lens", {rd_len, wr_len}, 0);
        reset_reset_n = 1'b1;
        wr_exp.delete(); rd_exp.delete();
        repeat (5) @(negedge clk_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
